// File: rtl/cache_def.sv
// Shared cache/memory interface types and arbiter definitions.
package cache_def;

  typedef struct packed {
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
    logic         valid;
  } mem_req_type;

  typedef struct packed {
    logic [127:0] data;
    logic         ready;
  } mem_data_type;

  typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_type;

  localparam int unsigned ARB_MAX_REQ = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first pending index at or after ptr, wrapping.
module rr_arbiter #(
  parameter int unsigned N = 2,
  localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  pending,
  input  logic [IW-1:0] ptr,
  output logic [IW-1:0] grant,
  output logic          any_valid
);

  int unsigned idx;

  always_comb begin
    grant     = '0;
    any_valid = 1'b0;
    idx       = 0;
    for (int unsigned i = 0; i < N; i++) begin
      idx = (32'(ptr) + i) % N;
      if (!any_valid && pending[IW'(idx)]) begin
        grant     = IW'(idx);
        any_valid = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cache_mem_arbiter.sv
// Shares one main-memory port between N_REQ cache controllers with round-robin
// grant, per-port pending slots, response routing and a sticky watchdog.
module cache_mem_arbiter
  import cache_def::*;
#(
  parameter int unsigned N_REQ   = 2,
  parameter int unsigned TIMEOUT = 1024
) (
  input  logic                     clk,
  input  logic                     rst,
  input  mem_req_type              req_in  [N_REQ],
  output mem_data_type             rsp_out [N_REQ],
  output mem_req_type              mem_req,
  input  mem_data_type             mem_data,
  output logic [$clog2(N_REQ)-1:0] grant_id,
  output logic                     busy,
  output logic                     timeout_err
);

  localparam int unsigned IW   = $clog2(N_REQ);
  localparam int unsigned WD_W = $clog2(TIMEOUT + 1) + 1;

  arb_state_type    state;
  mem_req_type      slot [N_REQ];
  logic [N_REQ-1:0] pending;
  logic [IW-1:0]    rr_ptr;
  logic [IW-1:0]    pick;
  logic [IW-1:0]    next_ptr;
  logic             any_pending;
  logic             done;
  logic [WD_W-1:0]  wd_cnt;

  rr_arbiter #(.N(N_REQ)) u_rr (
    .pending   (pending),
    .ptr       (rr_ptr),
    .grant     (pick),
    .any_valid (any_pending)
  );

  always_comb begin
    pending = '0;
    for (int unsigned i = 0; i < N_REQ; i++) pending[i] = slot[i].valid;
  end

  assign done     = (state == ARB_BUSY) && mem_data.ready;
  assign next_ptr = (grant_id == IW'(N_REQ - 1)) ? '0 : grant_id + 1'b1;
  assign busy     = (state == ARB_BUSY);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARB_IDLE;
      rr_ptr      <= '0;
      grant_id    <= '0;
      wd_cnt      <= '0;
      timeout_err <= 1'b0;
      for (int unsigned i = 0; i < N_REQ; i++) slot[i] <= '0;
    end else begin
      // The completing port may re-request on its ready cycle; refill instead of clear.
      for (int unsigned i = 0; i < N_REQ; i++) begin
        if (done && grant_id == IW'(i))
          slot[i] <= req_in[i].valid ? req_in[i] : '0;
        else if (!slot[i].valid && req_in[i].valid)
          slot[i] <= req_in[i];
      end
      case (state)
        ARB_IDLE: begin
          if (any_pending) begin
            grant_id <= pick;
            wd_cnt   <= '0;
            state    <= ARB_BUSY;
          end
        end
        ARB_BUSY: begin
          if (mem_data.ready) begin
            rr_ptr <= next_ptr;
            state  <= ARB_IDLE;
          end else begin
            if (wd_cnt != '1) wd_cnt <= wd_cnt + 1'b1;
            if (TIMEOUT != 0 && wd_cnt == WD_W'(TIMEOUT - 1)) timeout_err <= 1'b1;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

  always_comb begin
    mem_req = '0;
    if (state == ARB_BUSY) begin
      mem_req       = slot[grant_id];
      mem_req.valid = 1'b1;
    end
  end

  always_comb begin
    for (int unsigned i = 0; i < N_REQ; i++)
      rsp_out[i] = (done && grant_id == IW'(i)) ? mem_data : '0;
  end

endmodule

// File: tb/tb_cache_mem_arbiter.sv
// Scoreboard bench for cache_mem_arbiter: directed stimulus pushes expected
// memory requests and responses; a negedge monitor pops and compares them.
module tb_cache_mem_arbiter;
  import cache_def::*;

  typedef struct {
    int unsigned  port;
    logic [31:0]  addr;
    logic [127:0] data;
    logic         rw;
  } req_exp_t;

  typedef struct {
    int unsigned  port;
    logic [127:0] data;
  } rsp_exp_t;

  logic         clk;
  logic         rst;
  mem_req_type  req_in  [2];
  mem_data_type rsp_out [2];
  mem_req_type  mem_req;
  mem_data_type mem_data;
  logic [0:0]   grant_id;
  logic         busy;
  logic         timeout_err;

  req_exp_t exp_req[$];
  rsp_exp_t exp_rsp[$];
  req_exp_t er;
  rsp_exp_t es;
  mem_req_type prev_req;
  logic        prev_valid;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [127:0] D_A5 = {16{8'hA5}};

  cache_mem_arbiter #(.N_REQ(2), .TIMEOUT(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_in      (req_in),
    .rsp_out     (rsp_out),
    .mem_req     (mem_req),
    .mem_data    (mem_data),
    .grant_id    (grant_id),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [161:0] act, input logic [161:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input int unsigned port, input logic [31:0] addr,
                       input logic [127:0] data, input logic rw);
    req_exp_t e;
    e.port = port; e.addr = addr; e.data = data; e.rw = rw;
    exp_req.push_back(e);
    req_in[port] = '{addr: addr, data: data, rw: rw, valid: 1'b1};
  endtask

  task automatic clear_req(input int unsigned port);
    req_in[port] = '0;
  endtask

  task automatic respond(input int unsigned port, input logic [127:0] data);
    rsp_exp_t e;
    e.port = port; e.data = data;
    exp_rsp.push_back(e);
    mem_data = '{data: data, ready: 1'b1};
    tick();
    mem_data = '0;
  endtask

  task automatic reset_dut();
    rst = 1'b1;
    tick();
    tick();
    check("rst_mem_req", 162'(mem_req), 162'(0));
    check("rst_rsp0", 162'(rsp_out[0]), 162'(0));
    check("rst_rsp1", 162'(rsp_out[1]), 162'(0));
    check("rst_grant", 162'(grant_id), 162'(0));
    check("rst_busy", 162'(busy), 162'(0));
    check("rst_timeout", 162'(timeout_err), 162'(0));
    rst = 1'b0;
  endtask

  always @(negedge clk) begin
    if (rst) begin
      prev_valid <= 1'b0;
    end else begin
      if (mem_req.valid) begin
        if (!prev_valid) begin
          if (exp_req.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_req: got addr %0h expected no request", mem_req.addr);
          end else begin
            er = exp_req.pop_front();
            check("req_addr", 162'(mem_req.addr), 162'(er.addr));
            check("req_data", 162'(mem_req.data), 162'(er.data));
            check("req_rw", 162'(mem_req.rw), 162'(er.rw));
            check("req_grant", 162'(grant_id), 162'(er.port));
          end
        end else begin
          check("req_hold", 162'(mem_req), 162'(prev_req));
        end
      end
      for (int i = 0; i < 2; i++) begin
        if (rsp_out[i].ready) begin
          if (exp_rsp.size() == 0) begin
            n_cmp++; n_err++;
            $display("FAIL unexpected_rsp: got ready on port %0d expected none", i);
          end else begin
            es = exp_rsp.pop_front();
            check("rsp_port", 162'(i), 162'(es.port));
            check("rsp_data", 162'(rsp_out[i].data), 162'(es.data));
            check("rsp_other_zero", 162'(rsp_out[1-i]), 162'(0));
          end
        end
      end
      prev_req   <= mem_req;
      prev_valid <= mem_req.valid;
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

  initial begin
    rst        = 1'b1;
    req_in[0]  = '0;
    req_in[1]  = '0;
    mem_data   = '0;
    prev_valid = 1'b0;
    prev_req   = '0;

    // Single read with 2-cycle request latency and ready in the 5th BUSY cycle
    reset_dut();
    issue(0, 32'h0000_1230, '0, 1'b0);
    tick();
    clear_req(0);
    check("t1_valid_cyc1", 162'(mem_req.valid), 162'(0));
    tick();
    check("t1_valid_cyc2", 162'(mem_req.valid), 162'(1));
    check("t1_grant", 162'(grant_id), 162'(0));
    check("t1_busy", 162'(busy), 162'(1));
    repeat (4) tick();
    check("t1_addr_held", 162'(mem_req.addr), 162'(32'h0000_1230));
    respond(0, D_A5);
    check("t1_idle", 162'(busy), 162'(0));

    // Contention from rr_ptr=0: port0 then port1
    reset_dut();
    issue(0, 32'h0000_1000, 128'h11, 1'b0);
    issue(1, 32'h0000_4000, 128'h22, 1'b0);
    tick();
    clear_req(0);
    clear_req(1);
    tick();
    check("t2_grant_first", 162'(grant_id), 162'(0));
    check("t2_addr_first", 162'(mem_req.addr), 162'(32'h0000_1000));
    repeat (2) tick();
    respond(0, 128'h1111);
    check("t2_idle_between", 162'(busy), 162'(0));
    tick();
    check("t2_grant_second", 162'(grant_id), 162'(1));
    check("t2_addr_second", 162'(mem_req.addr), 162'(32'h0000_4000));
    respond(1, 128'h2222);

    // Write-back then same-cycle allocate while port0 is pending
    issue(1, 32'h00AB_C010, 128'hDEAD_BEEF, 1'b1);
    tick();
    clear_req(1);
    tick();
    check("t3_grant_wb", 162'(grant_id), 162'(1));
    issue(0, 32'h0000_2000, 128'h33, 1'b0);
    tick();
    clear_req(0);
    issue(1, 32'h0000_C010, 128'h0, 1'b0);
    respond(1, 128'h4444);
    clear_req(1);
    check("t3_idle_after_wb", 162'(busy), 162'(0));
    tick();
    check("t3_grant_port0", 162'(grant_id), 162'(0));
    respond(0, 128'h5555);
    tick();
    check("t3_grant_alloc", 162'(grant_id), 162'(1));
    check("t3_alloc_addr", 162'(mem_req.addr), 162'(32'h0000_C010));
    check("t3_alloc_rw", 162'(mem_req.rw), 162'(0));
    respond(1, 128'h6666);

    // Hold stability: 20 delayed cycles while port0 keeps requesting
    issue(0, 32'h0000_3000, 128'h77, 1'b1);
    tick();
    clear_req(0);
    tick();
    check("t4_busy", 162'(busy), 162'(1));
    for (int i = 0; i < 20; i++) begin
      req_in[0] = '{addr: 32'hBAD0_0000 + 32'(i), data: 128'(i), rw: 1'b0, valid: 1'b1};
      tick();
    end
    clear_req(0);
    check("t4_addr_held", 162'(mem_req.addr), 162'(32'h0000_3000));
    respond(0, 128'h8888);
    for (int i = 0; i < 3; i++) begin
      check("t4_no_extra", 162'(busy), 162'(0));
      tick();
    end
    mem_data = '{data: 128'h9999, ready: 1'b1};
    #1;
    check("t4_idle_ready_rsp0", 162'(rsp_out[0]), 162'(0));
    check("t4_idle_ready_rsp1", 162'(rsp_out[1]), 162'(0));
    tick();
    mem_data = '0;
    check("t4_idle_ready_busy", 162'(busy), 162'(0));

    // Watchdog with TIMEOUT=8, memory never ready
    reset_dut();
    issue(0, 32'h0000_5000, 128'hAA, 1'b0);
    tick();
    clear_req(0);
    tick();
    check("t5_busy", 162'(busy), 162'(1));
    check("t5_to_cyc0", 162'(timeout_err), 162'(0));
    repeat (7) tick();
    check("t5_to_cyc7", 162'(timeout_err), 162'(0));
    tick();
    check("t5_to_cyc8", 162'(timeout_err), 162'(1));
    repeat (3) tick();
    check("t5_to_sticky", 162'(timeout_err), 162'(1));
    check("t5_still_busy", 162'(busy), 162'(1));

    // Reset on cycle 3 of a port1 transaction with port0 pending
    reset_dut();
    issue(1, 32'h0000_6000, 128'hBB, 1'b0);
    tick();
    clear_req(1);
    tick();
    check("t6_grant1", 162'(grant_id), 162'(1));
    req_in[0] = '{addr: 32'h0000_7000, data: 128'hCC, rw: 1'b0, valid: 1'b1};
    tick();
    clear_req(0);
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("t6_valid", 162'(mem_req.valid), 162'(0));
    check("t6_busy", 162'(busy), 162'(0));
    check("t6_grant", 162'(grant_id), 162'(0));
    for (int i = 0; i < 3; i++) begin
      tick();
      check("t6_slots_clear", 162'(busy), 162'(0));
    end

    check("end_req_queue", 162'(exp_req.size()), 162'(0));
    check("end_rsp_queue", 162'(exp_rsp.size()), 162'(0));

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cache_mem_arbiter.md
Name: cache_mem_arbiter

Overview:
- Shares one main-memory port between N_REQ direct-mapped cache controllers, e.g. I-cache and D-cache, each driving mem_req_type and consuming mem_data_type.
- Captures single-cycle request pulses into per-port pending slots.
- Grants round-robin and holds the downstream request stable until memory signals ready.
- Routes the response back to the granted port only, and flags a stuck memory with a watchdog.

Parameters:
- N_REQ, 2, number of cache requesters (2..4).
- TIMEOUT, 1024, cycles in BUSY before timeout_err is raised; 0 disables the watchdog.

Ports:
- clk  input  1  clock.
- rst  input  1  reset.
- req_in[N_REQ]  input  mem_req_type (162b)  per-port request: addr 32, data 128, rw, valid.
- rsp_out[N_REQ]  output  mem_data_type (129b)  per-port response: data 128, ready.
- mem_req  output  mem_req_type  to memory controller.
- mem_data  input  mem_data_type  from memory controller.
- grant_id  output  $clog2(N_REQ)  index of the port currently owning memory.
- busy  output  1  a transaction is outstanding downstream.
- timeout_err  output  1  sticky watchdog flag.

Behaviour:
- Reset: rst is synchronous, active-high.
  - On reset: all pending slots cleared, state=IDLE, rr_ptr=0, wd_cnt=0.
  - Outputs after reset: mem_req all zero, every rsp_out zero, grant_id=0, busy=0, timeout_err=0.
- Pending capture:
  - When req_in[i].valid=1 and slot i is empty, slot i latches addr/data/rw on that edge. Valid may be a 1-cycle pulse or a level.
  - If slot i is full, or port i is being serviced, a new valid is ignored. The requester never re-requests before its ready.
- State IDLE:
  - When any slot is pending, pick the first pending index at or after rr_ptr, wrapping modulo N_REQ.
  - Then set grant_id, go to BUSY, clear wd_cnt.
  - A request captured this cycle can be granted next cycle at the earliest. Request-to-memory-valid latency is 2 cycles from the pulse.
- State BUSY:
  - mem_req = granted slot contents with valid=1. It is held constant every cycle until mem_data.ready.
  - Non-granted rsp_out are zero.
- On mem_data.ready=1 in BUSY, in the same cycle (combinational):
  - rsp_out[grant_id] = mem_data, so ready=1 and data is passed through.
  - At the edge: the slot is cleared, rr_ptr = grant_id+1 mod N_REQ, state goes to IDLE.
- Same-cycle re-request: if the granted port pulses valid in the same cycle its ready is returned (dirty write-back followed by allocate), the slot is refilled instead of cleared.
  - The refilled slot is eligible next IDLE cycle but loses priority to other pending ports (rr_ptr has advanced).
- Ready outside BUSY: mem_data.ready in IDLE is ignored and not forwarded.
- Watchdog:
  - wd_cnt counts up in BUSY, saturating.
  - When wd_cnt reaches TIMEOUT-1 without ready, timeout_err is set. It stays set until rst.
  - The transaction is not aborted.
- Reset mid-transaction: the outstanding request is dropped (mem_req.valid=0 the next cycle). Memory must also be reset.
- busy = (state==BUSY).

Decomposition:
- Reuse cache_def for mem_req_type and mem_data_type.
- Add arb_state_type {ARB_IDLE, ARB_BUSY} to cache_def.
- Add ARB_MAX_REQ=4 to cache_def.
- One natural sub-module: rr_arbiter (pure round-robin picker: pending vector + pointer -> grant index + any_valid). Combinational, reusable for tag/data port sharing later.

Test Plan:
- Single read: port0 pulses valid addr=0x0000_1230 rw=0.
  - Expect mem_req.valid=1 two cycles later, addr held.
  - Memory ready after 5 cycles with data=128'hA5.. gives rsp_out[0].ready=1, data A5.. in the same cycle; rsp_out[1] stays 0.
- Contention: both ports pulse in the same cycle with rr_ptr=0.
  - Port0 is served first, then port1. grant_id sequence 0 then 1.
  - Port1 addr 0x0000_4000 appears on mem_req only after port0's ready.
- Write-back then allocate: port1 issues rw=1 addr=0x00AB_C010.
  - On its ready it pulses rw=0 addr=0x0000_C010 while port0 is pending.
  - Expect port0 served next, then port1's allocate.
- Hold stability: memory delays ready 20 cycles while port0 pulses valid repeatedly.
  - mem_req bits are unchanged for all 20 cycles; no extra transactions.
- Watchdog: TIMEOUT=8, memory never ready.
  - timeout_err=1 exactly 8 cycles after entering BUSY; it stays 1 until rst.
- Reset mid-BUSY: assert rst on cycle 3 of a transaction.
  - Next cycle: mem_req.valid=0, busy=0, pending slots clear, grant_id=0.
